mdu_iter: RTL and testbench

Parametrised iterative multiply/divide unit for the pipelined MIPS core, the multi-cycle companion to the single-cycle Alu in EX. It executes MULT/MULTU/DIV/DIVU over WIDTH-bit operands using one shift-add or restore-subtract step per cycle and commits the results to architectural HI/LO registers. It also services MTHI/MTLO. While an operation runs it raises `busy`, which the hazard unit uses to stall any instruction that reads HI/LO or issues another multiply/divide.

---
 rtl/mdu_iter.sv | 152 +++++++++++++++
 tb/tb_mdu_iter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// Iterative MIPS multiply/divide unit: one shift-add or restoring-subtract step per cycle,
// with sign fix-up and commit to the architectural HI/LO registers. Also handles MTHI/MTLO.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               div0;
    logic [WIDTH-1:0]   a_raw;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   rem;
    logic [2*WIDTH-1:0] acc;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ok;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
        logic signed [WIDTH-1:0] sv;
        sv = $signed(v);
        return en ? -sv : sv;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
        logic signed [2*WIDTH-1:0] sv;
        sv = $signed(v);
        return en ? -sv : sv;
    endfunction

    // op[0] marks the signed variants; operands are reduced to magnitudes on entry
    assign a_neg = op[0] & a[WIDTH-1];
    assign b_neg = op[0] & b[WIDTH-1];
    assign mag_a = neg_w(a, a_neg);
    assign mag_b = neg_w(b, b_neg);

    // Multiply: acc = {partial product, remaining multiplier bits}
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
                   + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});

    // Divide: acc[WIDTH-1:0] shifts the dividend out and the quotient in
    assign div_shift = {rem, acc[WIDTH-1]};
    assign div_ok    = div_shift >= {1'b0, mcand};
    assign div_diff  = WIDTH'(div_shift - {1'b0, mcand});

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !op[2]) state_nxt = RUN;
            RUN:     if (cnt == CNT_W'(WIDTH-1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            a_raw  <= '0;
            mcand  <= '0;
            rem    <= '0;
            acc    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !op[2]) begin
                        busy   <= 1'b1;
                        cnt    <= '0;
                        is_div <= op[1];
                        a_raw  <= a;
                        div0   <= op[1] && (b == '0);
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= op[1] & a_neg;
                        rem    <= '0;
                        if (op[1]) begin
                            acc   <= {{WIDTH{1'b0}}, mag_a};
                            mcand <= mag_b;
                        end else begin
                            acc   <= {{WIDTH{1'b0}}, mag_b};
                            mcand <= mag_a;
                        end
                    end else if (start && !op[1]) begin
                        if (op[0]) lo <= a;
                        else       hi <= a;
                        done <= 1'b1;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (is_div) begin
                        rem              <= div_ok ? div_diff : div_shift[WIDTH-1:0];
                        acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], div_ok};
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (!is_div) begin
                        {hi, lo} <= neg_2w(acc, neg_q);
                    end else if (div0) begin
                        hi <= a_raw;
                        lo <= '1;
                    end else begin
                        // Most-negative / -1 falls out naturally: magnitude quotient 2^(W-1) negates to itself
                        hi <= neg_w(rem, neg_r);
                        lo <= neg_w(acc[WIDTH-1:0], neg_q);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: cycle-level reference model of HI/LO/busy/done plus directed vectors.
module tb_mdu_iter;
    localparam int W = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    int          m_left = 0;
    logic [63:0] m_pend = '0;

    mdu_iter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Architectural result {hi, lo} from plain arithmetic
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        int qi;
        int ri;
        sx = $signed(x);
        sy = $signed(y);
        case (o)
            3'b000: return {32'b0, x} * {32'b0, y};
            3'b001: return sx * sy;
            3'b010: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            default: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                qi = $signed(x) / $signed(y);
                ri = $signed(x) % $signed(y);
                return {ri, qi};
            end
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    {m_hi, m_lo} <= m_pend;
                    m_done <= 1'b1;
                    m_busy <= 1'b0;
                end
            end else if (start) begin
                if (!op[2]) begin
                    m_pend <= ref_result(op, a, b);
                    m_left <= W + 1;
                    m_busy <= 1'b1;
                end else if (op == 3'b100) begin
                    m_hi   <= a;
                    m_done <= 1'b1;
                end else if (op == 3'b101) begin
                    m_lo   <= a;
                    m_done <= 1'b1;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (check_en) begin
            chk("model_busy", {31'b0, busy}, {31'b0, m_busy});
            chk("model_done", {31'b0, done}, {31'b0, m_done});
            chk("model_hi", hi, m_hi);
            chk("model_lo", lo, m_lo);
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(negedge clk);
        start = 1'b0;
        op    = 3'b111;
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_done(output int nbusy);
        nbusy = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            if (busy) nbusy++;
            @(negedge clk);
        end
        chk("done_seen", {31'b0, done}, 32'd1);
    endtask

    task automatic run(input string name, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] ehi, input logic [31:0] elo);
        int nb;
        issue(o, x, y);
        wait_done(nb);
        chk({name, "_hi"}, hi, ehi);
        chk({name, "_lo"}, lo, elo);
    endtask

    initial begin
        int nb;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_en = 1'b1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        rst_n = 1'b1;

        issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(nb);
        chk("multu_busy_cycles", nb, 32'd33);
        chk("multu_max_hi", hi, 32'hFFFF_FFFE);
        chk("multu_max_lo", lo, 32'h0000_0001);

        run("mult_neg", 3'b001, 32'h8000_00FA, 32'h0000_0004, 32'hFFFF_FFFE, 32'h0000_03E8);
        run("multu_same", 3'b000, 32'h8000_00FA, 32'h0000_0004, 32'h0000_0002, 32'h0000_03E8);
        run("div_m7", 3'b011, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run("divu", 3'b010, 32'h8000_00FA, 32'h0000_0004, 32'h0000_0002, 32'h2000_003E);
        run("divu_by0", 3'b010, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF);
        run("div_ovf", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run("div_by0", 3'b011, 32'hFFFF_FFF0, 32'h0000_0000, 32'hFFFF_FFF0, 32'hFFFF_FFFF);

        issue(3'b100, 32'hDEAD_BEEF, 32'h0);
        chk("mthi_hi", hi, 32'hDEAD_BEEF);
        chk("mthi_busy", {31'b0, busy}, 32'd0);
        chk("mthi_done", {31'b0, done}, 32'd1);

        issue(3'b000, 32'd3, 32'd5);
        for (int i = 0; i < 4; i++) begin
            start = 1'b1;
            op    = i[0] ? 3'b101 : 3'b010;
            a     = 32'h1111_1111;
            b     = 32'd1;
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            chk("hold_hi", hi, 32'hDEAD_BEEF);
        end
        wait_done(nb);
        chk("mul3x5_hi", hi, 32'h0);
        chk("mul3x5_lo", lo, 32'h0000_000F);
        start = 1'b1;
        op    = 3'b000;
        a     = 32'd7;
        b     = 32'd6;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", {31'b0, busy}, 32'd1);
        wait_done(nb);
        chk("b2b_lo", lo, 32'h0000_002A);

        issue(3'b101, 32'h1234_5678, 32'h0);
        chk("mtlo_lo", lo, 32'h1234_5678);
        issue(3'b110, 32'hAAAA_AAAA, 32'h0);
        chk("nop_done", {31'b0, done}, 32'd0);
        chk("nop_busy", {31'b0, busy}, 32'd0);
        chk("nop_lo", lo, 32'h1234_5678);

        issue(3'b011, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_done", {31'b0, done}, 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        run("multu_after_rst", 3'b000, 32'd2, 32'd3, 32'd0, 32'd6);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
